// File: rtl/pc_flow_unit_pkg.sv
// pc_flow_unit_pkg: shared alucode, operand-type and control constants for the PC flow unit.
package pc_flow_unit_pkg;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic [31:0] RESET_PC = 32'h0000_8000;

  localparam logic [5:0] ALU_LUI  = 6'd0;
  localparam logic [5:0] ALU_JAL  = 6'd1;
  localparam logic [5:0] ALU_JALR = 6'd2;
  localparam logic [5:0] ALU_BEQ  = 6'd3;
  localparam logic [5:0] ALU_BNE  = 6'd4;
  localparam logic [5:0] ALU_BLT  = 6'd5;
  localparam logic [5:0] ALU_BGE  = 6'd6;
  localparam logic [5:0] ALU_BLTU = 6'd7;
  localparam logic [5:0] ALU_BGEU = 6'd8;
  localparam logic [5:0] ALU_ADD  = 6'd18;
  localparam logic [5:0] ALU_NOP  = 6'd63;

  localparam logic [1:0] OP_TYPE_NONE = 2'd0;
  localparam logic [1:0] OP_TYPE_REG  = 2'd1;
  localparam logic [1:0] OP_TYPE_IMM  = 2'd2;
  localparam logic [1:0] OP_TYPE_PC   = 2'd3;

  function automatic logic is_branch(input logic [5:0] code);
    return code inside {ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
  endfunction

  function automatic logic [31:0] op_sel(input logic [1:0] t, input logic [31:0] reg_d,
                                         input logic [31:0] imm_d, input logic [31:0] pc_d);
    return t == OP_TYPE_REG ? reg_d : t == OP_TYPE_IMM ? imm_d : t == OP_TYPE_PC ? pc_d : 32'h0;
  endfunction
endpackage

// File: rtl/pc_flow_unit_btb_table.sv
// pc_flow_unit_btb_table: direct-mapped BTB with 2-bit counters; lookup from IF, training from EX.
module pc_flow_unit_btb_table
  import pc_flow_unit_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int PC_BITS  = 16
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic [PC_BITS-1:0] i_pred_pc,
  output logic [31:0]        o_pred_npc,
  input  logic [PC_BITS-1:0] i_upd_pc,
  input  logic [PC_BITS-1:0] i_upd_npc,
  input  logic               i_upd_taken
);
  localparam int NENT     = 1 << IDX_BITS;
  localparam int TAG_BITS = PC_BITS - IDX_BITS - 2;

  logic [NENT-1:0]     r_valid;
  logic [1:0]          r_cnt    [NENT];
  logic [TAG_BITS-1:0] r_tag    [NENT];
  logic [PC_BITS-1:0]  r_target [NENT];

  logic [IDX_BITS-1:0] w_ridx, w_uidx;
  logic [TAG_BITS-1:0] w_rtag, w_utag;
  logic                w_rhit, w_uhit, w_taken, w_upd;
  logic [1:0]          w_ucnt, w_ncnt;

  assign w_ridx = i_pred_pc[IDX_BITS+1:2];
  assign w_rtag = i_pred_pc[PC_BITS-1:IDX_BITS+2];
  assign w_uidx = i_upd_pc[IDX_BITS+1:2];
  assign w_utag = i_upd_pc[PC_BITS-1:IDX_BITS+2];

  assign w_rhit = r_valid[w_ridx] && r_tag[w_ridx] == w_rtag;
  assign w_uhit = r_valid[w_uidx] && r_tag[w_uidx] == w_utag;

  // Counter MSB set means predict taken; the sum deliberately carries past the stored PC width.
  assign o_pred_npc = (w_rhit && r_cnt[w_ridx][1]) ? {{(32-PC_BITS){1'b0}}, r_target[w_ridx]}
                                                   : {{(32-PC_BITS){1'b0}}, i_pred_pc} + 32'd4;

  // Jumps never assert br_taken, so a non-sequential next PC also counts as taken.
  assign w_taken = i_upd_taken || i_upd_npc != i_upd_pc + PC_BITS'(4);
  assign w_upd   = i_upd_pc != '0;
  assign w_ucnt  = r_cnt[w_uidx];
  assign w_ncnt  = !w_uhit ? 2'd2
                 : w_taken ? (w_ucnt == 2'd3 ? 2'd3 : w_ucnt + 2'd1)
                 : (w_ucnt == 2'd0 ? 2'd0 : w_ucnt - 2'd1);

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_valid <= '0;
      for (int i = 0; i < NENT; i++) r_cnt[i] <= 2'd0;
    end else if (w_upd && (w_taken || w_uhit)) begin
      r_valid[w_uidx] <= 1'b1;
      r_cnt[w_uidx]   <= w_ncnt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_nrst && w_upd && w_taken) begin
      r_tag[w_uidx]    <= w_utag;
      r_target[w_uidx] <= i_upd_npc;
    end
  end
endmodule

// File: rtl/pc_flow_unit.sv
// pc_flow_unit: BTB next-PC prediction, EX actual next-PC selection and ID ALU operand muxing.
module pc_flow_unit
  import pc_flow_unit_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int PC_BITS  = 16
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic [PC_BITS-1:0] i_pred_pc,
  output logic [31:0]        o_pred_npc,
  input  logic [PC_BITS-1:0] i_upd_pc,
  input  logic [PC_BITS-1:0] i_upd_npc,
  input  logic               i_upd_taken,
  input  logic [31:0]        i_ex_pc,
  input  logic [5:0]         i_ex_alucode,
  input  logic [31:0]        i_npc_default,
  input  logic [31:0]        i_npc_branch,
  input  logic [31:0]        i_npc_jalr,
  input  logic               i_br_taken,
  output logic [31:0]        o_ex_npc,
  input  logic [1:0]         i_aluop1_type,
  input  logic [1:0]         i_aluop2_type,
  input  logic [31:0]        i_id_pc,
  input  logic [31:0]        i_regdata1,
  input  logic [31:0]        i_regdata2,
  input  logic [31:0]        i_imm,
  output logic [31:0]        o_oprl,
  output logic [31:0]        o_oprr
);
  logic w_bubble;

  pc_flow_unit_btb_table #(.IDX_BITS(IDX_BITS), .PC_BITS(PC_BITS)) u_btb (
    .i_clk       (i_clk),
    .i_nrst      (i_nrst),
    .i_pred_pc   (i_pred_pc),
    .o_pred_npc  (o_pred_npc),
    .i_upd_pc    (i_upd_pc),
    .i_upd_npc   (i_upd_npc),
    .i_upd_taken (i_upd_taken)
  );

  assign w_bubble = i_ex_pc == 32'h0;

  always_comb begin
    o_ex_npc = w_bubble                                ? i_npc_default
             : i_ex_alucode == ALU_JAL                 ? i_npc_branch
             : i_ex_alucode == ALU_JALR                ? {i_npc_jalr[31:1], 1'b0}
             : (is_branch(i_ex_alucode) && i_br_taken) ? i_npc_branch
             : i_npc_default;
    o_oprl = op_sel(i_aluop1_type, i_regdata1, i_imm, i_id_pc);
    o_oprr = op_sel(i_aluop2_type, i_regdata2, i_imm, i_id_pc);
  end
endmodule

// File: tb/tb_pc_flow_unit.sv
// tb_pc_flow_unit: directed test-plan steps followed by random traffic checked against a table model.
module tb_pc_flow_unit;
  import pc_flow_unit_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic [15:0] pred_pc, upd_pc, upd_npc;
  logic        upd_taken;
  logic [31:0] pred_npc;
  logic [31:0] ex_pc, npc_default, npc_branch, npc_jalr, ex_npc;
  logic [5:0]  ex_alucode;
  logic        br_taken;
  logic [1:0]  aluop1_type, aluop2_type;
  logic [31:0] id_pc, regdata1, regdata2, imm, oprl, oprr;

  int checks = 0;
  int fails  = 0;

  typedef struct {bit v; int tag; int tgt; int cnt;} ent_t;
  ent_t m[64];

  always #5 clk = ~clk;

  pc_flow_unit dut (
    .i_clk(clk), .i_nrst(nrst), .i_pred_pc(pred_pc), .o_pred_npc(pred_npc),
    .i_upd_pc(upd_pc), .i_upd_npc(upd_npc), .i_upd_taken(upd_taken),
    .i_ex_pc(ex_pc), .i_ex_alucode(ex_alucode), .i_npc_default(npc_default),
    .i_npc_branch(npc_branch), .i_npc_jalr(npc_jalr), .i_br_taken(br_taken),
    .o_ex_npc(ex_npc), .i_aluop1_type(aluop1_type), .i_aluop2_type(aluop2_type),
    .i_id_pc(id_pc), .i_regdata1(regdata1), .i_regdata2(regdata2), .i_imm(imm),
    .o_oprl(oprl), .o_oprr(oprr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int model_pred(input int pc);
    int idx = (pc / 4) % 64;
    if (m[idx].v && m[idx].tag == pc / 256 && m[idx].cnt >= 2) return m[idx].tgt;
    return pc + 4;
  endfunction

  function automatic void model_edge(input bit rn, input int pc, input int npc, input bit tk);
    int idx = (pc / 4) % 64;
    bit hit = m[idx].v && m[idx].tag == pc / 256;
    bit taken = tk || npc != (pc + 4) % 65536;
    if (!rn) begin
      foreach (m[i]) begin m[i].v = 0; m[i].cnt = 0; end
      return;
    end
    if (pc == 0) return;
    if (taken && hit) begin m[idx].cnt = (m[idx].cnt + 1 > 3) ? 3 : m[idx].cnt + 1; m[idx].tgt = npc; end
    else if (taken) m[idx] = '{1, pc / 256, npc, 2};
    else if (hit) m[idx].cnt = (m[idx].cnt - 1 < 0) ? 0 : m[idx].cnt - 1;
  endfunction

  function automatic logic [31:0] ref_npc();
    if (ex_pc == 0) return npc_default;
    case (ex_alucode)
      ALU_JAL:  return npc_branch;
      ALU_JALR: return npc_jalr & 32'hFFFF_FFFE;
      ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU: return br_taken ? npc_branch : npc_default;
      default:  return npc_default;
    endcase
  endfunction

  function automatic logic [31:0] ref_op(input logic [1:0] t, input logic [31:0] r);
    case (t)
      OP_TYPE_REG: return r;
      OP_TYPE_IMM: return imm;
      OP_TYPE_PC:  return id_pc;
      default:     return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge(nrst, int'(upd_pc), int'(upd_npc), upd_taken);
    @(negedge clk);
  endtask

  task automatic upd(input logic [15:0] pc, input logic [15:0] npc, input logic tk);
    upd_pc = pc; upd_npc = npc; upd_taken = tk;
    tick();
    upd_pc = 16'h0;
  endtask

  task automatic pred_is(input string tag, input logic [15:0] pc, input logic [31:0] exp);
    pred_pc = pc;
    #1;
    check(tag, pred_npc, exp);
    check({tag, "_model"}, pred_npc, 32'(model_pred(int'(pc))));
  endtask

  initial begin
    logic [5:0] codes [8];
    codes = '{ALU_JAL, ALU_JALR, ALU_BEQ, ALU_BNE, ALU_BLTU, ALU_BGEU, ALU_NOP, ALU_ADD};
    nrst = 1'b0; pred_pc = 16'h8010; upd_pc = 16'h0; upd_npc = 16'h0; upd_taken = 1'b0;
    ex_pc = 32'h8000; ex_alucode = ALU_NOP; npc_default = 32'h0; npc_branch = 32'h0; npc_jalr = 32'h0;
    br_taken = 1'b0; aluop1_type = OP_TYPE_NONE; aluop2_type = OP_TYPE_NONE;
    id_pc = 32'h0; regdata1 = 32'h0; regdata2 = 32'h0; imm = 32'h0;
    foreach (m[i]) m[i] = '{0, 0, 0, 0};
    tick();
    nrst = 1'b1;
    pred_is("reset_pred", 16'h8010, 32'h0000_8014);
    pred_is("wrap_pred", 16'hFFFC, 32'h0001_0000);

    upd(16'h8010, 16'h8000, 1'b1);
    pred_is("trained_hit", 16'h8010, 32'h0000_8000);
    pred_is("tag_miss", 16'h9010, 32'h0000_9014);

    upd(16'h8010, 16'h8014, 1'b0);
    pred_is("cnt1_pred", 16'h8010, 32'h0000_8014);
    upd(16'h8010, 16'h8014, 1'b0);
    pred_is("cnt0_pred", 16'h8010, 32'h0000_8014);
    upd(16'h8010, 16'h8000, 1'b1);
    pred_is("cnt1_again", 16'h8010, 32'h0000_8014);
    upd(16'h8010, 16'h8000, 1'b1);
    pred_is("cnt2_pred", 16'h8010, 32'h0000_8000);

    // Same-cycle read of the entry being written must see the old contents.
    upd_pc = 16'h8010; upd_npc = 16'h8100; upd_taken = 1'b1;
    pred_is("same_cycle_old", 16'h8010, 32'h0000_8000);
    tick();
    upd_pc = 16'h0;
    pred_is("write_visible", 16'h8010, 32'h0000_8100);

    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    pred_is("reset_mid_train", 16'h8010, 32'h0000_8014);

    ex_alucode = ALU_JALR; npc_jalr = 32'h8103; #1;
    check("sel_jalr", ex_npc, 32'h8102);
    ex_alucode = ALU_BNE; br_taken = 1'b0; npc_default = 32'h8024; npc_branch = 32'h8300; #1;
    check("sel_bne_nt", ex_npc, 32'h8024);
    ex_alucode = ALU_JAL; npc_branch = 32'h8200; #1;
    check("sel_jal", ex_npc, 32'h8200);
    ex_pc = 32'h0; #1;
    check("sel_bubble", ex_npc, 32'h8024);
    ex_pc = 32'h8000;

    aluop1_type = OP_TYPE_PC; id_pc = 32'h8040; aluop2_type = OP_TYPE_IMM; imm = 32'hFFFF_FFFC;
    regdata1 = 32'h1111; regdata2 = 32'h2222; #1;
    check("oprl_pc", oprl, 32'h8040);
    check("oprr_imm", oprr, 32'hFFFF_FFFC);
    aluop1_type = OP_TYPE_NONE; aluop2_type = OP_TYPE_NONE; #1;
    check("oprl_none", oprl, 32'h0);
    check("oprr_none", oprr, 32'h0);
    aluop1_type = OP_TYPE_REG; aluop2_type = OP_TYPE_REG; #1;
    check("oprl_reg", oprl, 32'h1111);
    check("oprr_reg", oprr, 32'h2222);

    for (int n = 0; n < 600; n++) begin
      nrst = ($urandom_range(0, 99) != 0);
      upd_pc = ($urandom_range(0, 9) == 0) ? 16'h0
             : 16'h8000 + 16'($urandom_range(0, 3) * 4) + 16'($urandom_range(0, 2) * 16'h1000);
      upd_npc = ($urandom_range(0, 1) == 1) ? upd_pc + 16'd4 : 16'($urandom & 32'hFFFC);
      upd_taken = 1'($urandom);
      pred_pc = 16'h8000 + 16'($urandom_range(0, 3) * 4) + 16'($urandom_range(0, 2) * 16'h1000);
      ex_pc = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      ex_alucode = codes[$urandom_range(0, 7)];
      br_taken = 1'($urandom);
      npc_default = $urandom; npc_branch = $urandom; npc_jalr = $urandom;
      aluop1_type = 2'($urandom); aluop2_type = 2'($urandom);
      id_pc = $urandom; regdata1 = $urandom; regdata2 = $urandom; imm = $urandom;
      #1;
      check("rnd_pred", pred_npc, 32'(model_pred(int'(pred_pc))));
      check("rnd_npc", ex_npc, ref_npc());
      check("rnd_oprl", oprl, ref_op(aluop1_type, regdata1));
      check("rnd_oprr", oprr, ref_op(aluop2_type, regdata2));
      tick();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/pc_flow_unit.md
Name: pc_flow_unit

Overview:
Front/execute-side PC control block for the 5-stage RV32 pipeline (IF/ID/EX/MA/RW). It combines three functions:
- A BTB-based next-PC predictor queried in IF and trained from EX.
- The EX-stage actual next-PC selector.
- The ID-stage ALU operand multiplexer.
A mismatch between the EX actual next-PC and pc_ID triggers a pipeline flush in the surrounding core.

Parameters:
- IDX_BITS, 6: BTB index width (64 entries), index = PC[IDX_BITS+1:2].
- PC_BITS, 16: significant PC bits stored and compared; tag = PC[PC_BITS-1:IDX_BITS+2] (8 bits by default).

Ports:
- clk, in, 1: system clock, all state on rising edge.
- nrst, in, 1: reset, synchronous, active-low.
- pred_pc, in, 16: IF-stage PC (pc_IF[15:0]).
- pred_npc, out, 32: predicted next PC for IF.
- upd_pc, in, 16: EX-stage PC (pc_EX[15:0]); value 0 marks a bubble.
- upd_npc, in, 16: EX actual next PC [15:0].
- upd_taken, in, 1: ALU br_taken from EX.
- ex_pc, in, 32: EX PC.
- ex_alucode, in, 6: EX alucode.
- npc_default, in, 32: pc+4.
- npc_branch, in, 32: pc+imm.
- npc_jalr, in, 32: rs1+imm.
- br_taken, in, 1: ALU branch condition.
- ex_npc, out, 32: actual next PC.
- aluop1_type, in, 2: left operand source select.
- aluop2_type, in, 2: right operand source select.
- id_pc, in, 32: ID-stage PC.
- regdata1, in, 32: rs1 read data.
- regdata2, in, 32: rs2 read data.
- imm, in, 32: decoded immediate.
- oprl, out, 32: left ALU operand.
- oprr, out, 32: right ALU operand.

Behaviour:

BTB entry contents: valid, tag, 16-bit target, 2-bit saturating counter (0–1 not-taken, 2–3 taken).

Prediction (combinational from registered state):
- On hit (valid, tag equal) with counter ≥ 2: pred_npc = {16'h0, target}.
- Otherwise: pred_npc = {16'h0, pred_pc} + 4, computed in 32 bits, with no wrap at bit 16.

Update (rising edge, only when nrst=1 and upd_pc ≠ 0):
- Effective taken condition: taken = upd_taken OR (upd_npc ≠ upd_pc+4, computed 16-bit). This covers JAL/JALR.
- Taken and hit: counter++ (saturates at 3); target ← upd_npc.
- Taken and miss: allocate or overwrite the entry: valid=1, tag, target=upd_npc, counter=2.
- Not taken and hit: counter-- (saturates at 0); target unchanged.
- Not taken and miss: no change.

Write timing:
- A write is visible to prediction from the next cycle.
- Same-cycle read of the entry being written returns the old contents.

Reset (nrst=0 at the edge):
- All valid bits and counters are cleared.
- Tags and targets don't care.
- pred_npc = pred_pc+4 from the cycle after reset.
- Reset mid-training discards all history.

Next-PC selector (combinational):
- ALU_JAL → npc_branch.
- ALU_JALR → npc_jalr with bit0 cleared.
- ALU_BEQ/BNE/BLT/BGE/BLTU/BGEU with br_taken=1 → npc_branch.
- Anything else, including ALU_NOP and ex_pc=0 bubbles → npc_default.

Operand switch (combinational):
- oprl: OP_TYPE_REG → regdata1; OP_TYPE_IMM → imm; OP_TYPE_PC → id_pc; OP_TYPE_NONE → 0.
- oprr: same encoding with regdata2.
- Undefined codes → 0.

General:
- The only outputs with registered dependence are the BTB outputs.
- No handshakes; one prediction and one update per cycle.

Decomposition:
- Shared define package holds the ALU_* alucode constants, OP_TYPE_* operand-type constants, ENABLE/DISABLE, and the reset PC 'h8000.
- Natural sub-module: btb_table (storage, lookup, counter update).
- The selector and the operand mux stay inline.

Test Plan:
1. Reset with nrst=0, then pred_pc=0x8010 → pred_npc=0x00008014.
2. One cycle of upd_pc=0x8010, upd_npc=0x8000, upd_taken=1; then pred_pc=0x8010 → 0x00008000. pred_pc=0x9010 (same index, different tag) → 0x00009014.
3. Continue from 2 with two updates at 0x8010 of upd_npc=0x8014, upd_taken=0 → counter 2→1→0; predicts 0x8014 after the first update. A taken update then brings the counter back to 1 and the prediction stays 0x8014.
4. Mid-training nrst=0 for one cycle → previously trained 0x8010 predicts 0x8014.
5. Next-PC selector cases:
   - ex_alucode=ALU_JALR, npc_jalr=0x8103 → ex_npc=0x8102.
   - ALU_BNE, br_taken=0, npc_default=0x8024 → ex_npc=0x8024.
   - ALU_JAL, npc_branch=0x8200 → ex_npc=0x8200.
6. Operand switch: aluop1_type=OP_TYPE_PC, id_pc=0x8040, aluop2_type=OP_TYPE_IMM, imm=0xFFFFFFFC → oprl=0x8040, oprr=0xFFFFFFFC. Both types OP_TYPE_NONE → 0, 0.
